reaction_timer: RTL and testbench

//  Game engine and data source for the on-screen text layout. Debounced button drives a reaction-test FSM.
//  A 6-digit BCD stopwatch measures the reaction in ms.us (xxx.xxx).

---
 rtl/reaction_pkg.sv | 32 +++
 rtl/bcd_counter6.sv | 51 +++++
 rtl/reaction_timer.sv | 217 +++++++++++++++++++++
 tb/tb_reaction_timer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
`default_nettype none
// ============================================================================
// Package  : reaction_pkg
// Purpose  : Shared types and constants for the reaction timer: the status
//            code enum (which is also the FSM state encoding), the BCD
//            saturation value, and the LFSR seed, taps and step function.
// Revision : 1.0 - initial release
// ============================================================================
package reaction_pkg;

  // The state encoding is the status code shown on screen, so o_dst can be
  // taken straight from the state register.
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    READY = 3'b001,
    GO    = 3'b010,
    MISS  = 3'b011,
    HIT   = 3'b110
  } dst_e;

  localparam logic [23:0] BCD_MAX   = 24'h999999;

  // Galois LFSR for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter6.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter6
// Purpose  : Six-digit BCD up-counter with a ripple carry chain. Saturates at
//            999999 and never wraps.
// Ports    : clk  in   clock
//            rst  in   synchronous active-high reset (clears to 0)
//            clr  in   synchronous clear (clears to 0)
//            inc  in   add one this cycle (ignored when full)
//            q    out  [23:0] six BCD digits, [3:0] least significant
//            full out  q equals 999999
// Revision : 1.0 - initial release
// ============================================================================
module bcd_counter6
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [23:0] q,
  output logic        full
);

  logic [3:0] digit [6];
  logic [5:0] carry;

  assign full = (q == BCD_MAX);

  // carry[i] means digit i advances this cycle; gating the chain with ~full
  // is what makes the counter saturate instead of rolling to zero.
  always_comb begin
    carry[0] = inc & ~full;
    for (int i = 1; i < 6; i++) begin
      carry[i] = carry[i-1] && (digit[i-1] == 4'd9);
    end
  end

  for (genvar i = 0; i < 6; i++) begin : g_digit
    always_ff @(posedge clk) begin
      if (rst || clr) begin
        digit[i] <= 4'd0;
      end else if (carry[i]) begin
        digit[i] <= (digit[i] == 4'd9) ? 4'd0 : digit[i] + 4'd1;
      end
    end
    assign q[4*i +: 4] = digit[i];
  end

endmodule
`default_nettype wire

// File: rtl/reaction_timer.sv
`default_nettype none
// ============================================================================
// Module   : reaction_timer
// Purpose  : Reaction-test game engine. A synchronised (optionally debounced)
//            push-button drives the IDLE/READY/GO/MISS/HIT FSM; a BCD
//            stopwatch measures the reaction time in ms.us, and the Last and
//            Best results are kept for the display.
// Ports    : i_clk    in   system clock
//            i_rst    in   synchronous active-high reset
//            i_btn    in   raw asynchronous button, active high
//            i_bcdmux in   0: o_bcd = Last, 1: o_bcd = Best
//            o_bcd    out  [23:0] six BCD digits (hundreds of ms .. units of us)
//            o_dst    out  [2:0] status code (state register)
//            o_lit    out  high while in GO
//            o_miss   out  high while in MISS
//            o_init   out  high until the first HIT after reset
// Config   : REACT_DEBOUNCE_EN - when defined, the synchronised button level
//            must be stable for DEBOUNCE_MS ms before it is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int US_DIV          = 25,
  parameter int DELAY_MIN_MS    = 1000,
  parameter int DELAY_RAND_BITS = 11
`ifdef REACT_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_MS     = 5
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_btn,
  input  logic        i_bcdmux,
  output logic [23:0] o_bcd,
  output logic [2:0]  o_dst,
  output logic        o_lit,
  output logic        o_miss,
  output logic        o_init
);

  localparam int PRE_W  = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int WAIT_W = $clog2(DELAY_MIN_MS + (1 << DELAY_RAND_BITS));

  // --------------------------------------------------------------------------
  // Button synchroniser and press detection
  // --------------------------------------------------------------------------
  logic btn_s1, btn_s2, level, level_q, press;
  logic us_tick;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      btn_s1  <= i_btn;
      btn_s2  <= btn_s1;
      level_q <= level;
    end
  end

`ifdef REACT_DEBOUNCE_EN
  localparam int DB_TICKS = DEBOUNCE_MS * 1000;
  localparam int DB_W     = $clog2(DB_TICKS + 1);

  logic            deb;
  logic [DB_W-1:0] db_cnt;

  // Count us ticks while the synchronised level disagrees with the accepted
  // level; any return to agreement restarts the count, so glitches vanish.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      deb    <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s2 == deb) begin
      db_cnt <= '0;
    end else if (us_tick) begin
      if (db_cnt == DB_W'(DB_TICKS - 1)) begin
        deb    <= btn_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign level = deb;
`else
  assign level = btn_s2;
`endif

  assign press = level & ~level_q;

  // --------------------------------------------------------------------------
  // Timing sources: us prescaler, ms counter, LFSR
  // --------------------------------------------------------------------------
  logic [PRE_W-1:0]  presc;
  logic [9:0]        ms_cnt;
  logic [15:0]       lfsr;
  logic              ms_tick;
  logic              ready_entry, go_entry, timer_clr;

  dst_e              state;
  logic [WAIT_W-1:0] wait_ms;
  logic [WAIT_W-1:0] wait_load;

  assign us_tick = (presc == PRE_W'(US_DIV - 1));
  assign ms_tick = us_tick && (ms_cnt == 10'd999);

  // Restarting the timebase on READY entry makes the minimum wait exact
  // rather than up to one ms short; on GO entry it aligns the first
  // stopwatch tick to a full microsecond.
  assign timer_clr = ready_entry | go_entry;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc  <= '0;
      ms_cnt <= '0;
      lfsr   <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
      if (timer_clr) begin
        presc  <= '0;
        ms_cnt <= '0;
      end else if (us_tick) begin
        presc  <= '0;
        ms_cnt <= (ms_cnt == 10'd999) ? 10'd0 : ms_cnt + 10'd1;
      end else begin
        presc  <= presc + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stopwatch
  // --------------------------------------------------------------------------
  logic [23:0] sw_q;
  logic        sw_full, sw_inc, timeout;

  assign sw_inc  = us_tick && (state == GO);
  assign timeout = sw_inc && sw_full;

  bcd_counter6 u_stopwatch (
    .clk  (i_clk),
    .rst  (i_rst),
    .clr  (go_entry),
    .inc  (sw_inc),
    .q    (sw_q),
    .full (sw_full)
  );

  // --------------------------------------------------------------------------
  // Reaction FSM with Last/Best/init bookkeeping
  // --------------------------------------------------------------------------
  logic [23:0] last, best;
  logic        init;

  assign wait_load   = WAIT_W'(DELAY_MIN_MS) + WAIT_W'(lfsr[DELAY_RAND_BITS-1:0]);
  assign ready_entry = press && ((state == IDLE) || (state == MISS) || (state == HIT));
  assign go_entry    = (state == READY) && !press && ms_tick && (wait_ms <= WAIT_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      wait_ms <= '0;
      last    <= '0;
      best    <= '0;
      init    <= 1'b1;
    end else begin
      case (state)
        IDLE, MISS, HIT: begin
          if (press) begin
            state   <= READY;
            wait_ms <= wait_load;
          end
        end
        READY: begin
          if (press) begin
            state <= MISS;
          end else if (ms_tick) begin
            if (wait_ms <= WAIT_W'(1)) begin
              state <= GO;
            end else begin
              wait_ms <= wait_ms - 1'b1;
            end
          end
        end
        GO: begin
          // A press in the timeout cycle still counts as a hit.
          if (press) begin
            state <= HIT;
            last  <= sw_q;
            // BCD digits order the same as plain binary, so a 24-bit
            // unsigned compare ranks the times correctly.
            if (init || (sw_q < best)) begin
              best <= sw_q;
            end
            init  <= 1'b0;
          end else if (timeout) begin
            state <= MISS;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_dst  = state;
  assign o_lit  = (state == GO);
  assign o_miss = (state == MISS);
  assign o_init = init;
  assign o_bcd  = i_bcdmux ? best : last;

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reaction_timer
// Purpose  : Directed self-checking bench for reaction_timer with
//            US_DIV=2, DELAY_MIN_MS=1, DELAY_RAND_BITS=1. With
//            REACT_DEBOUNCE_EN defined only reset and debounce scenarios run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reaction_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn;
  logic        bcdmux;
  logic [23:0] bcd;
  logic [2:0]  dst;
  logic        lit, miss, init;

  int checks   = 0;
  int failures = 0;

  reaction_timer #(
    .US_DIV          (2),
    .DELAY_MIN_MS    (1),
    .DELAY_RAND_BITS (1)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_btn    (btn),
    .i_bcdmux (bcdmux),
    .o_bcd    (bcd),
    .o_dst    (dst),
    .o_lit    (lit),
    .o_miss   (miss),
    .o_init   (init)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press from IDLE/MISS/HIT, release, then wait (bounded) for GO.
  // Returns at the first sample where lit is high.
  task automatic enter_go(output bit ok);
    btn = 1'b1;
    step(3);
    btn = 1'b0;
    step(4);
    ok = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (lit === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  // Called right after GO entry; the press lands after exactly t us ticks.
  task automatic hit_at(input int t);
    step(2 * t - 2);
    btn = 1'b1;
    step(3);
  endtask

  task automatic test_reset;
    rst = 1'b1; btn = 1'b0; bcdmux = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);
    checks++; if (dst !== 3'b000) begin failures++; $display("FAIL reset_dst got=%b exp=000", dst); end
    checks++; if (init !== 1'b1) begin failures++; $display("FAIL reset_init got=%b exp=1", init); end
    checks++; if (lit !== 1'b0) begin failures++; $display("FAIL reset_lit got=%b exp=0", lit); end
    checks++; if (miss !== 1'b0) begin failures++; $display("FAIL reset_miss got=%b exp=0", miss); end
    checks++; if (bcd !== 24'h000000) begin failures++; $display("FAIL reset_last got=%h exp=000000", bcd); end
    bcdmux = 1'b1; #1;
    checks++; if (bcd !== 24'h000000) begin failures++; $display("FAIL reset_best got=%h exp=000000", bcd); end
    bcdmux = 1'b0; #1;
  endtask

  task automatic test_idle_to_ready;
    logic [2:0] exp_dst;
    btn = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step(1);
      exp_dst = (c == 3) ? 3'b001 : 3'b000;
      checks++; if (dst !== exp_dst) begin failures++; $display("FAIL press_lat_dst cyc=%0d got=%b exp=%b", c, dst, exp_dst); end
      checks++; if (lit !== 1'b0 || miss !== 1'b0) begin failures++; $display("FAIL press_lat_flags cyc=%0d got=%b%b exp=00", c, lit, miss); end
      checks++; if (init !== 1'b1 || bcd !== 24'h0) begin failures++; $display("FAIL press_lat_data cyc=%0d got=%b/%h exp=1/000000", c, init, bcd); end
    end
    btn = 1'b0;
    step(4);
  endtask

  task automatic test_early_miss;
    btn = 1'b1;
    step(3);
    checks++; if (dst !== 3'b011) begin failures++; $display("FAIL early_dst got=%b exp=011", dst); end
    checks++; if (miss !== 1'b1 || lit !== 1'b0) begin failures++; $display("FAIL early_flags got=%b%b exp=10", miss, lit); end
    checks++; if (init !== 1'b1) begin failures++; $display("FAIL early_init got=%b exp=1", init); end
    checks++; if (bcd !== 24'h0) begin failures++; $display("FAIL early_last got=%h exp=000000", bcd); end
    bcdmux = 1'b1; #1;
    checks++; if (bcd !== 24'h0) begin failures++; $display("FAIL early_best got=%h exp=000000", bcd); end
    bcdmux = 1'b0;
    btn = 1'b0;
    step(4);
  endtask

  task automatic test_first_hit;
    bit ok;
    enter_go(ok);
    checks++; if (!ok) begin failures++; $display("FAIL go1_wait got=no_go exp=go"); end
    checks++; if (dst !== 3'b010) begin failures++; $display("FAIL go1_dst got=%b exp=010", dst); end
    hit_at(123456);
    checks++; if (dst !== 3'b110) begin failures++; $display("FAIL hit1_dst got=%b exp=110", dst); end
    checks++; if (lit !== 1'b0) begin failures++; $display("FAIL hit1_lit got=%b exp=0", lit); end
    checks++; if (bcd !== 24'h123456) begin failures++; $display("FAIL hit1_last got=%h exp=123456", bcd); end
    bcdmux = 1'b1; #1;
    checks++; if (bcd !== 24'h123456) begin failures++; $display("FAIL hit1_best got=%h exp=123456", bcd); end
    bcdmux = 1'b0; #1;
    checks++; if (init !== 1'b0) begin failures++; $display("FAIL hit1_init got=%b exp=0", init); end
    btn = 1'b0;
    step(4);
  endtask

  task automatic test_rounds;
    bit ok;
    enter_go(ok);
    checks++; if (!ok) begin failures++; $display("FAIL go2_wait got=no_go exp=go"); end
    hit_at(200000);
    checks++; if (dst !== 3'b110) begin failures++; $display("FAIL hit2_dst got=%b exp=110", dst); end
    checks++; if (bcd !== 24'h200000) begin failures++; $display("FAIL hit2_last got=%h exp=200000", bcd); end
    bcdmux = 1'b1; #1;
    checks++; if (bcd !== 24'h123456) begin failures++; $display("FAIL hit2_best got=%h exp=123456", bcd); end
    bcdmux = 1'b0;
    btn = 1'b0;
    step(4);
    enter_go(ok);
    checks++; if (!ok) begin failures++; $display("FAIL go3_wait got=no_go exp=go"); end
    hit_at(50000);
    checks++; if (bcd !== 24'h050000) begin failures++; $display("FAIL hit3_last got=%h exp=050000", bcd); end
    bcdmux = 1'b1; #1;
    checks++; if (bcd !== 24'h050000) begin failures++; $display("FAIL hit3_best got=%h exp=050000", bcd); end
    bcdmux = 1'b0;
    btn = 1'b0;
    step(4);
  endtask

  task automatic test_timeout;
    bit ok;
    enter_go(ok);
    checks++; if (!ok) begin failures++; $display("FAIL go4_wait got=no_go exp=go"); end
    // After 999999 ticks the stopwatch is full but still in GO.
    step(1999999);
    checks++; if (dst !== 3'b010 || lit !== 1'b1) begin failures++; $display("FAIL pre_timeout got=%b/%b exp=010/1", dst, lit); end
    step(1);
    checks++; if (dst !== 3'b011) begin failures++; $display("FAIL timeout_dst got=%b exp=011", dst); end
    checks++; if (miss !== 1'b1 || lit !== 1'b0) begin failures++; $display("FAIL timeout_flags got=%b%b exp=10", miss, lit); end
    checks++; if (bcd !== 24'h050000) begin failures++; $display("FAIL timeout_last got=%h exp=050000", bcd); end
    bcdmux = 1'b1; #1;
    checks++; if (bcd !== 24'h050000) begin failures++; $display("FAIL timeout_best got=%h exp=050000", bcd); end
    bcdmux = 1'b0; #1;
    checks++; if (init !== 1'b0) begin failures++; $display("FAIL timeout_init got=%b exp=0", init); end
  endtask

  task automatic test_debounce;
    // 3 ms glitch (6000 cycles at 2 cycles/us) must be ignored.
    btn = 1'b1;
    step(6000);
    btn = 1'b0;
    step(12000);
    checks++; if (dst !== 3'b000) begin failures++; $display("FAIL glitch_dst got=%b exp=000", dst); end
    // 6 ms press: not yet accepted at 4.5 ms, accepted by 6 ms.
    btn = 1'b1;
    step(9000);
    checks++; if (dst !== 3'b000) begin failures++; $display("FAIL deb_early_dst got=%b exp=000", dst); end
    step(3000);
    checks++; if (dst !== 3'b001) begin failures++; $display("FAIL deb_press_dst got=%b exp=001", dst); end
    btn = 1'b0;
    step(4);
  endtask

  initial begin
    test_reset();
`ifdef REACT_DEBOUNCE_EN
    test_debounce();
`else
    test_idle_to_ready();
    test_early_miss();
    test_first_hit();
    test_rounds();
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
